// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned SAT_VALUE  = 9999;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the filter output stage and the display digit driver.
interface bin2bcd_seq_if #(
  parameter int unsigned WIDTH = 16
);
  import bin2bcd_seq_pkg::*;

  logic [WIDTH-1:0]    bin;
  logic                start;
  logic                busy;
  logic                done;
  logic [NIBBLE_W-1:0] ones;
  logic [NIBBLE_W-1:0] tens;
  logic [NIBBLE_W-1:0] hundreds;
  logic [NIBBLE_W-1:0] thousands;
  logic                ovf;

  modport master (
    output bin, start,
    input  busy, done, ones, tens, hundreds, thousands, ovf
  );

  modport slave (
    input  bin, start,
    output busy, done, ones, tens, hundreds, thousands, ovf
  );

endinterface

// File: rtl/bcd_add3.sv
// Per-nibble double-dabble correction: nibbles of 5 or more get 3 added before the shift.
module bcd_add3 (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  always_comb begin
    nib_out = nib_in;
    if (nib_in >= 4'd5) nib_out = nib_in + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Clamped 16-bit binary to four-digit BCD, one bit per clock; digits held between done pulses.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  bin2bcd_seq_if.slave      bus
);

  localparam int unsigned BCD_W = DIGITS * NIBBLE_W;
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic             ovf_cap;

  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_next;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] clamped;
  logic             ovf_in;

  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_in  (bcd_sr[d*NIBBLE_W +: NIBBLE_W]),
      .nib_out (bcd_adj[d*NIBBLE_W +: NIBBLE_W])
    );
  end

  always_comb begin
    ovf_in   = bus.bin > WIDTH'(SAT_VALUE);
    clamped  = ovf_in ? WIDTH'(SAT_VALUE) : bus.bin;
    bcd_next = {bcd_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
    bin_next = {bin_sr[WIDTH-2:0], 1'b0};
  end

  // Digit outputs load only from the final shifted value, never the live shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bin_sr        <= '0;
      bcd_sr        <= '0;
      ovf_cap       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.ones      <= '0;
      bus.tens      <= '0;
      bus.hundreds  <= '0;
      bus.thousands <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_sr   <= clamped;
            ovf_cap  <= ovf_in;
            bcd_sr   <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sr <= bcd_next;
          bin_sr <= bin_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bus.ones      <= bcd_next[0*NIBBLE_W +: NIBBLE_W];
            bus.tens      <= bcd_next[1*NIBBLE_W +: NIBBLE_W];
            bus.hundreds  <= bcd_next[2*NIBBLE_W +: NIBBLE_W];
            bus.thousands <= bcd_next[3*NIBBLE_W +: NIBBLE_W];
            bus.ovf       <= ovf_cap;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks of bin2bcd_seq against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(16)) bus ();

  bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [16:0] prev;

  // {ovf, thousands, hundreds, tens, ones} from plain decimal arithmetic
  function automatic logic [16:0] model(input int unsigned v);
    int unsigned c;
    c = (v > 9999) ? 9999 : v;
    return {(v > 9999), 4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.ovf, bus.thousands, bus.hundreds, bus.tens, bus.ones};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      tick();
      chk("idle_hold", {13'd0, bus.busy, bus.done, observed()}, {13'd0, 2'b00, prev});
    end
  endtask

  // Start a conversion of v; if retrig is nonzero, pulse start with 8888 at that cycle.
  task automatic run_conv(input int unsigned v, input int unsigned retrig);
    logic [16:0] exp;
    int unsigned cyc;
    exp       = model(v);
    bus.bin   = 16'(v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bin   = 16'($urandom);
    cyc       = 0;
    while (!bus.done && cyc < 20) begin
      chk("busy_hold", {14'd0, bus.busy, observed()}, {14'd0, 1'b1, prev});
      if (retrig != 0 && cyc + 1 == retrig) begin
        bus.start = 1'b1;
        bus.bin   = 16'd8888;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    chk("latency", cyc, 32'd16);
    chk("done_busy", {30'd0, bus.done, bus.busy}, {30'd0, 2'b10});
    chk("result", {15'd0, observed()}, {15'd0, exp});
    prev = exp;
  endtask

  initial begin
    rst       = 1'b0;
    bus.bin   = '0;
    bus.start = 1'b0;
    prev      = '0;
    repeat (3) tick();
    chk("reset_state", {13'd0, bus.busy, bus.done, observed()}, 32'd0);
    rst = 1'b1;
    idle(2);

    run_conv(0, 0);
    idle(2);
    run_conv(1234, 0);
    idle(3);
    run_conv(9999, 0);
    run_conv(10000, 0);
    run_conv(65535, 0);
    idle(1);

    // reset seven cycles into a conversion
    bus.bin   = 16'd4321;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    rst = 1'b0;
    #1;
    chk("reset_async", {13'd0, bus.busy, bus.done, observed()}, 32'd0);
    tick();
    chk("reset_held", {13'd0, bus.busy, bus.done, observed()}, 32'd0);
    rst  = 1'b1;
    prev = '0;
    idle(2);
    run_conv(4321, 0);
    idle(1);

    run_conv(57, 5);
    run_conv(500, 0);
    idle(3);

    for (int i = 0; i < 24; i++) begin
      int unsigned v;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9999);
        1:       v = $urandom_range(9990, 10010);
        default: v = $urandom_range(0, 65535);
      endcase
      run_conv(v, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
